// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: text segment geometry,
// fetch FSM encoding and the IF/ID pipeline bundle.
package mips_pkg;

  localparam logic [31:0] TEXT_BASE  = 32'h0000_3000;
  localparam int          IM_WORDS   = 4096;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  // First address past the end of instruction memory.
  localparam logic [31:0] TEXT_LIMIT = TEXT_BASE + 32'(4 * IM_WORDS);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
  } ifid_t;

  // A fetch address is illegal if misaligned or outside the text segment.
  function automatic logic fetch_addr_bad(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < TEXT_BASE) || (pc >= TEXT_LIMIT);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: D-stage control in, instruction memory port,
// IF/ID contents and fault status out.
interface fetch_ctrl_if;

  logic        stall_d;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] im_instr;
  logic [31:0] im_pc;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        valid_d;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  // Pipeline / memory side: drives control and returns instructions.
  modport master (
    output stall_d, redir_valid, redir_pc, flush, flush_pc, im_instr,
    input  im_pc, instr_d, pc_d, pc8_d, valid_d, fetch_fault, fault_pc
  );

  // Fetch controller side.
  modport slave (
    input  stall_d, redir_valid, redir_pc, flush, flush_pc, im_instr,
    output im_pc, instr_d, pc_d, pc8_d, valid_d, fetch_fault, fault_pc
  );

endinterface

// File: rtl/fetch_ctrl_ifid_reg.sv
// IF/ID pipeline register. Clear wins over load; with neither asserted
// the contents hold (stall or no capture this cycle).
module ifid_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output ifid_t       ifid_o
);

  ifid_t ifid_q;

  // Reset to a bubble at the boot PC, clear inserts a NOP, load captures.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q <= '{instr: NOP_WORD, pc: TEXT_BASE, pc8: TEXT_BASE + 32'd8, valid: 1'b0};
    end else if (clr_i) begin
      ifid_q.instr <= NOP_WORD;
      ifid_q.valid <= 1'b0;
    end else if (load_i) begin
      ifid_q <= '{instr: instr_i, pc: pc_i, pc8: pc_i + 32'd8, valid: 1'b1};
    end
  end

  assign ifid_o = ifid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, presents it to the ROM,
// captures the returned word into IF/ID and handles stall, redirect
// (with one delay slot), flush and fetch-address faults.
module fetch_ctrl
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.slave  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic         ifid_clr, ifid_load;
  ifid_t        ifid;

  // State, PC and fault status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      fpc_q      <= TEXT_BASE;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // Next-state: flush > stall > fault on capture > redirect > sequential.
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    ifid_clr   = 1'b0;
    ifid_load  = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.flush) begin
          fpc_d    = bus.flush_pc;
          ifid_clr = 1'b1;
        end else if (bus.stall_d) begin
          // Hold everything; D re-presents any redirect after the stall.
          fpc_d = fpc_q;
        end else if (fetch_addr_bad(fpc_q)) begin
          fault_d    = 1'b1;
          fault_pc_d = fpc_q;
          ifid_clr   = 1'b1;
          state_d    = HALT;
        end else begin
          // The word at the current PC is the delay slot on a redirect.
          ifid_load = 1'b1;
          fpc_d     = bus.redir_valid ? bus.redir_pc : fpc_q + 32'd4;
        end
      end
      HALT: begin
        ifid_clr = 1'b1;
        if (bus.flush) begin
          fpc_d   = bus.flush_pc;
          fault_d = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  ifid_reg u_ifid (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (ifid_clr),
    .load_i  (ifid_load),
    .instr_i (bus.im_instr),
    .pc_i    (fpc_q),
    .ifid_o  (ifid)
  );

  assign bus.im_pc       = fpc_q;
  assign bus.instr_d     = ifid.instr;
  assign bus.pc_d        = ifid.pc;
  assign bus.pc8_d       = ifid.pc8;
  assign bus.valid_d     = ifid.valid;
  assign bus.fetch_fault = fault_q;
  assign bus.fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by random control
// traffic, all compared against a sequential reference model of fetch.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] rom [4096];

  // Combinational instruction ROM driven by the DUT's fetch address.
  always_comb begin
    if (bus.im_pc >= 32'h3000 && bus.im_pc < 32'h7000)
      bus.im_instr = rom[(bus.im_pc - 32'h3000) >> 2];
    else
      bus.im_instr = 32'hBAD0_BAD0;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural fetch state.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc8, m_fpc;
  logic        m_valid, m_fault, m_boot, m_halt;

  function automatic logic m_illegal(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a >= 32'h3000 + 4 * 4096);
  endfunction

  task automatic model_step();
    if (reset) begin
      m_pc = 32'h3000; m_instr = 32'h0; m_pcd = 32'h3000; m_pc8 = 32'h3008;
      m_valid = 1'b0; m_fault = 1'b0; m_fpc = 32'h0; m_boot = 1'b1; m_halt = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halt) begin
      m_valid = 1'b0; m_instr = 32'h0;
      if (bus.flush) begin
        m_halt = 1'b0; m_fault = 1'b0; m_pc = bus.flush_pc;
      end
    end else if (bus.flush) begin
      m_pc = bus.flush_pc; m_instr = 32'h0; m_valid = 1'b0;
    end else if (bus.stall_d) begin
      // nothing moves
    end else if (m_illegal(m_pc)) begin
      m_fault = 1'b1; m_fpc = m_pc; m_instr = 32'h0; m_valid = 1'b0; m_halt = 1'b1;
    end else begin
      m_instr = rom[(m_pc - 32'h3000) / 4];
      m_pcd   = m_pc;
      m_pc8   = m_pc + 8;
      m_valid = 1'b1;
      m_pc    = bus.redir_valid ? bus.redir_pc : m_pc + 4;
    end
  endtask

  task automatic compare_all();
    check("im_pc", bus.im_pc, m_pc);
    check("valid_d", bus.valid_d, m_valid);
    check("instr_d", bus.instr_d, m_instr);
    check("fetch_fault", bus.fetch_fault, m_fault);
    check("fault_pc", bus.fault_pc, m_fpc);
    if (m_valid) begin
      check("pc_d", bus.pc_d, m_pcd);
      check("pc8_d", bus.pc8_d, m_pc8);
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic rv,
                       input logic [31:0] rpc, input logic fl, input logic [31:0] fpc);
    reset = rst; bus.stall_d = st; bus.redir_valid = rv;
    bus.redir_pc = rpc; bus.flush = fl; bus.flush_pc = fpc;
  endtask

  // One clock: model and DUT advance on the same edge, outputs sampled 1ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      cycle();
    end
  endtask

  logic [31:0] tgt;

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = $urandom;
    m_pc = 32'h0; m_instr = 32'h0; m_pcd = 32'h0; m_pc8 = 32'h0; m_fpc = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0; m_boot = 1'b1; m_halt = 1'b0;

    // Reset state, explicit values.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle();
    check("rst_pc8_d", bus.pc8_d, 32'h3008);
    check("rst_pc_d", bus.pc_d, 32'h3000);

    // BOOT bubble, then A, B.
    idle(1);
    check("boot_valid", bus.valid_d, 1'b0);
    idle(1);
    check("first_instr", bus.instr_d, rom[0]);
    idle(1);

    // Stall two cycles holding B, then C.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0); cycle();
    drive(1'b0, 1'b1, 1'b1, 32'h3100, 1'b0, 32'h0); cycle();
    idle(1);

    // Redirect with delay slot.
    drive(1'b0, 1'b0, 1'b1, 32'h3100, 1'b0, 32'h0); cycle();
    idle(2);

    // Flush beats stall and redirect; then stall beats redirect.
    drive(1'b0, 1'b1, 1'b1, 32'h3200, 1'b1, 32'h4180); cycle();
    drive(1'b0, 1'b1, 1'b1, 32'h3200, 1'b0, 32'h0); cycle();
    idle(2);

    // Misaligned redirect faults, HALT holds, flush recovers to A.
    drive(1'b0, 1'b0, 1'b1, 32'h3002, 1'b0, 32'h0); cycle();
    idle(3);
    check("halt_fault_pc", bus.fault_pc, 32'h3002);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3000); cycle();
    idle(2);

    // Run off the end of the text segment.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h6FF8); cycle();
    idle(4);
    check("end_fault_pc", bus.fault_pc, 32'h7000);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3000); cycle();

    // Reset mid-operation overrides a simultaneous flush.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5000); cycle();
    idle(2);

    // Random control traffic.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0:       tgt = 32'h3000 + ($urandom_range(0, 2) == 0 ? $urandom_range(1, 3)
                                  : 32'(4 * $urandom_range(4096, 4200)));
        1, 2:    tgt = 32'h6FF0 + 32'(4 * $urandom_range(0, 3));
        default: tgt = 32'h3000 + 32'(4 * $urandom_range(0, 4095));
      endcase
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0,
            tgt,
            $urandom_range(0, 19) == 0,
            32'h3000 + 32'(4 * $urandom_range(0, 4095)));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the instruction memory for the 5-stage MIPS pipeline.
- Owns the PC register and drives the word-addressed instruction ROM (base 0x0000_3000, 4096 words) combinationally.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles D-stage stalls, branch/jump redirects (one architectural delay slot), pipeline flush, and fetch-address faults.

Parameters:
- TEXT_BASE, 32'h0000_3000, reset PC and lowest legal fetch address.
- IM_WORDS, 4096, instruction memory depth in words; legal range is [TEXT_BASE, TEXT_BASE+4*IM_WORDS).
- NOP_WORD, 32'h0000_0000, word inserted into IF/ID on flush or fault.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- stall_d  in  1  D stage cannot accept; hold PC and IF/ID.
- redir_valid  in  1  branch taken / jump / jr resolved in D this cycle.
- redir_pc  in  32  target address for redir_valid.
- flush  in  1  exception/eret: clear IF/ID, load PC from flush_pc.
- flush_pc  in  32  new PC on flush.
- im_instr  in  32  instruction word returned combinationally by memory for im_pc.
- im_pc  out  32  current fetch address to instruction memory.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC of instr_d.
- pc8_d  out  32  pc_d+8 (link address).
- valid_d  out  1  IF/ID holds a real instruction.
- fetch_fault  out  1  sticky: misaligned or out-of-range fetch detected.
- fault_pc  out  32  PC that caused the fault.

Behaviour:
- Reset values:
  - PC=TEXT_BASE, instr_d=NOP_WORD, pc_d=TEXT_BASE, pc8_d=TEXT_BASE+8, valid_d=0, fetch_fault=0, fault_pc=0.
  - FSM=BOOT.
  - Reset asserted mid-operation overrides every other input that cycle.
- FSM states: BOOT, RUN, HALT.
  - BOOT: lasts exactly one cycle after reset deasserts. im_pc=PC, IF/ID stays at its reset value, then go to RUN. This first cycle produces no instruction.
  - RUN: normal fetch.
  - HALT: entered on fault.
- RUN next-state priority, highest first:
  - (1) flush: PC<=flush_pc, IF/ID<=NOP with valid_d=0. Flush beats stall and redirect.
  - (2) stall_d: PC and IF/ID hold. redir_valid is ignored, because D re-presents the branch after the stall clears.
  - (3) redir_valid: PC<=redir_pc. IF/ID<={im_instr, PC}, valid_d=1. This is the delay slot; it is not squashed.
  - (4) otherwise: PC<=PC+4, IF/ID<={im_instr, PC}, valid_d=1.
- Arithmetic:
  - PC+4 and pc_d+8 are 32-bit modulo.
  - Memory index is (PC-TEXT_BASE)>>2. Range checking makes wrap-around irrelevant.
- Fault check is combinational on the PC being captured: PC[1:0]!=0, PC<TEXT_BASE, or PC>=TEXT_BASE+4*IM_WORDS.
  - When a capture into IF/ID would occur on a faulting PC: fetch_fault<=1, fault_pc<=PC, IF/ID<=NOP with valid_d=0, go to HALT.
  - The last legal word (TEXT_BASE+4*IM_WORDS-4) is fetched normally. The following PC faults on the next cycle.
  - During a stall the fault check is suppressed and no capture occurs.
- HALT:
  - PC frozen, valid_d=0, fetch_fault held at 1.
  - flush exits to RUN with PC<=flush_pc and clears fetch_fault.
  - reset also exits.
- Latency: an instruction at PC reaches instr_d one cycle after PC is presented, provided there is no stall.

Decomposition:
- Shared package (mips_pkg) holds:
  - TEXT_BASE, IM_WORDS, NOP_WORD.
  - The FSM state encoding enum {BOOT, RUN, HALT}.
  - The IF/ID bundle type {instr, pc, pc8, valid}.
- One natural sub-module, ifid_reg: the IF/ID register with hold/clear/load controls. PC logic and the FSM stay in fetch_ctrl.

Test Plan:
- Reset then run 4 cycles with ROM words A,B,C,D at 0x3000..0x300C -> BOOT cycle gives valid_d=0; then instr_d=A/pc_d=0x3000, B/0x3004, C/0x3008 on successive cycles; pc8_d=0x3008 with A.
- stall_d high 2 cycles while instr_d=B -> instr_d stays B, im_pc stays 0x3008; release gives C next.
- redir_valid with redir_pc=0x3100 while PC=0x3008 -> instr_d=C (delay slot, valid_d=1), next im_pc=0x3100, then instr_d=word@0x3100.
- stall_d, redir_valid and flush (flush_pc=0x4180) in the same cycle -> valid_d=0, im_pc=0x4180 next cycle. Same test without flush -> redirect ignored, all state held.
- redir_pc=0x3002 -> fetch_fault=1, fault_pc=0x3002, valid_d=0, PC frozen. Then flush to 0x3000 -> fault cleared, fetch resumes with A.
- Run sequentially from PC=0x6FFC -> word@0x6FFC is captured valid. Next cycle PC=0x7000 faults with fault_pc=0x7000.
